// File: rtl/l2_flush_walker_if.sv
// rtl/l2_flush_walker_if.sv - control, cache_mem port and writeback bundle for the L2 flush walker
interface l2_flush_walker_if #(
    parameter int TAG_W = 12,
    parameter int SET_W = 14,
    parameter int WAY_W = 3,
    parameter int CNT_W = 18
);
    logic                   start_i;
    logic                   mode_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   rd_en_o;
    logic [SET_W-1:0]       rd_set_o;
    logic [WAY_W-1:0]       rd_way_o;
    logic [TAG_W-1:0]       rd_tag_i;
    logic [1:0]             rd_state_i;
    logic                   wr_en_o;
    logic [SET_W-1:0]       wr_set_o;
    logic [WAY_W-1:0]       wr_way_o;
    logic [1:0]             wr_state_o;
    logic                   wb_valid_o;
    logic                   wb_ready_i;
    logic [TAG_W+SET_W-1:0] wb_addr_o;
    logic [CNT_W-1:0]       wb_count_o;

    modport master (
        input  start_i, mode_i, rd_tag_i, rd_state_i, wb_ready_i,
        output busy_o, done_o, rd_en_o, rd_set_o, rd_way_o,
               wr_en_o, wr_set_o, wr_way_o, wr_state_o,
               wb_valid_o, wb_addr_o, wb_count_o
    );

    modport slave (
        output start_i, mode_i, rd_tag_i, rd_state_i, wb_ready_i,
        input  busy_o, done_o, rd_en_o, rd_set_o, rd_way_o,
               wr_en_o, wr_set_o, wr_way_o, wr_state_o,
               wb_valid_o, wb_addr_o, wb_count_o
    );
endinterface

// File: rtl/l2_flush_walker.sv
// rtl/l2_flush_walker.sv - walks every L2 set/way, optionally writes back M lines, then invalidates
module l2_flush_walker #(
    parameter int SETS  = 16384,
    parameter int WAYS  = 8,
    parameter int TAG_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    l2_flush_walker_if.master bus
);
    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int CNT_W = $clog2(SETS * WAYS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_INV   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             mode_q,  mode_d;
    logic [SET_W-1:0] set_q,   set_d;
    logic [WAY_W-1:0] way_q,   way_d;
    logic [TAG_W-1:0] tag_q,   tag_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic last_way;
    logic last_line;

    assign last_way  = (way_q == WAY_W'(WAYS - 1));
    assign last_line = last_way && (set_q == SET_W'(SETS - 1));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        set_d   = set_q;
        way_d   = way_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    mode_d  = bus.mode_i;
                    set_d   = '0;
                    way_d   = '0;
                    tag_d   = '0;
                    cnt_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_CHECK;
            S_CHECK: begin
                tag_d   = bus.rd_tag_i;
                state_d = (mode_q && bus.rd_state_i == 2'b11) ? S_WB : S_INV;
            end
            S_WB: begin
                if (bus.wb_ready_i) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_INV;
                end
            end
            S_INV: begin
                // Indices freeze on the last line so they never wrap on their own.
                if (last_line) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                    if (last_way) begin
                        way_d = '0;
                        set_d = set_q + SET_W'(1);
                    end else begin
                        way_d = way_q + WAY_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            set_q   <= '0;
            way_q   <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            set_q   <= set_d;
            way_q   <= way_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.done_o     = (state_q == S_DONE);
    assign bus.rd_en_o    = (state_q == S_READ);
    assign bus.rd_set_o   = set_q;
    assign bus.rd_way_o   = way_q;
    assign bus.wr_en_o    = (state_q == S_INV);
    assign bus.wr_set_o   = set_q;
    assign bus.wr_way_o   = way_q;
    assign bus.wr_state_o = 2'b00;
    assign bus.wb_valid_o = (state_q == S_WB);
    assign bus.wb_addr_o  = {tag_q, set_q};
    assign bus.wb_count_o = cnt_q;
endmodule

// File: tb/tb_l2_flush_walker.sv
// tb/tb_l2_flush_walker.sv - scoreboard bench for l2_flush_walker with a 4-set, 2-way array model
module tb_l2_flush_walker;
    localparam int SETS  = 4;
    localparam int WAYS  = 2;
    localparam int TAG_W = 8;
    localparam int SET_W = 2;
    localparam int WAY_W = 1;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [TAG_W-1:0] mem_tag [SETS*WAYS];
    logic [1:0]       mem_st  [SETS*WAYS];

    logic [2:0]             exp_wr[$];
    logic [TAG_W+SET_W-1:0] exp_wb[$];
    int exp_wb_run = 1;
    int wb_run = 0;
    int stall_left = 0;
    logic ready_tie = 1'b0;

    l2_flush_walker_if #(.TAG_W(TAG_W), .SET_W(SET_W), .WAY_W(WAY_W), .CNT_W(CNT_W)) bus ();

    l2_flush_walker #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read array model: data appears the cycle after rd_en_o.
    always @(posedge clk) begin
        if (bus.rd_en_o) begin
            bus.rd_tag_i   <= mem_tag[{bus.rd_set_o, bus.rd_way_o}];
            bus.rd_state_i <= mem_st[{bus.rd_set_o, bus.rd_way_o}];
        end
    end

    always @(posedge clk) begin
        #1;
        if (bus.wb_valid_o && stall_left > 0) begin
            bus.wb_ready_i = 1'b0;
            stall_left--;
        end else if (bus.wb_valid_o) begin
            bus.wb_ready_i = 1'b1;
        end else begin
            bus.wb_ready_i = ready_tie;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ((int'(bus.rd_en_o) + int'(bus.wr_en_o) + int'(bus.wb_valid_o)) > 1) begin
                errors++;
                $display("FAIL strobe_exclusive rd=%0b wr=%0b wb=%0b required at most one", bus.rd_en_o, bus.wr_en_o, bus.wb_valid_o);
            end
            if (bus.wr_en_o) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected got set=%0d way=%0d required no write", bus.wr_set_o, bus.wr_way_o);
                end else begin
                    logic [2:0] e;
                    e = exp_wr.pop_front();
                    if ({bus.wr_set_o, bus.wr_way_o, bus.wr_state_o} !== {e, 2'b00}) begin
                        errors++;
                        $display("FAIL wr_order got set=%0d way=%0d st=%0d required set=%0d way=%0d st=0", bus.wr_set_o, bus.wr_way_o, bus.wr_state_o, e[2:1], e[0]);
                    end
                end
            end
            if (bus.wb_valid_o) begin
                wb_run++;
                checks++;
                if (exp_wb.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected got addr=%0h required no writeback", bus.wb_addr_o);
                end else if (bus.wb_addr_o !== exp_wb[0]) begin
                    errors++;
                    $display("FAIL wb_addr got %0h required %0h", bus.wb_addr_o, exp_wb[0]);
                end
                if (bus.wb_ready_i && exp_wb.size() != 0) begin
                    void'(exp_wb.pop_front());
                    checks++;
                    if (wb_run != exp_wb_run) begin
                        errors++;
                        $display("FAIL wb_valid_len got %0d required %0d", wb_run, exp_wb_run);
                    end
                    wb_run = 0;
                end
            end
        end
    end

    task automatic load_mem(input logic [1:0] st_all);
        for (int i = 0; i < SETS*WAYS; i++) begin
            mem_st[i]  = st_all;
            mem_tag[i] = TAG_W'($urandom_range(0, 255));
        end
    endtask

    task automatic push_expected(input logic mode);
        for (int i = 0; i < SETS*WAYS; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            exp_wr.push_back(idx);
            if (mode && mem_st[i] == 2'b11) exp_wb.push_back({mem_tag[i], idx[2:1]});
        end
    endtask

    task automatic do_walk(input logic mode, input int exp_len, input int exp_cnt, input bit extra);
        int n;
        int len;
        int k;
        bit seen;
        bit busy_bad;
        @(negedge clk);
        bus.mode_i  = mode;
        bus.start_i = 1'b1;
        n = cyc;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.mode_i  = ~mode;
        checks++;
        if ({bus.rd_en_o, bus.rd_set_o, bus.rd_way_o} !== 4'b1_00_0) begin
            errors++;
            $display("FAIL first_read got en=%0b set=%0d way=%0d required en=1 set=0 way=0", bus.rd_en_o, bus.rd_set_o, bus.rd_way_o);
        end
        seen = 0; busy_bad = 0; len = 0; k = 0;
        while (!seen && k < 100) begin
            if (bus.busy_o !== 1'b1) busy_bad = 1;
            if (bus.done_o === 1'b1) begin
                seen = 1;
                len  = cyc - n;
            end
            bus.start_i = extra && (seen || cyc == n + 3);
            @(negedge clk);
            k++;
        end
        bus.start_i = 1'b0;
        checks++;
        if (!seen || len != exp_len) begin
            errors++;
            $display("FAIL done_time got seen=%0b offset=%0d required offset=%0d", seen, len, exp_len);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL busy_window got a low busy_o during walk required 1 through DONE");
        end
        checks++;
        if ({bus.busy_o, bus.done_o, bus.wb_count_o} !== {1'b0, 1'b0, CNT_W'(exp_cnt)}) begin
            errors++;
            $display("FAIL post_done got busy=%0b done=%0b cnt=%0d required busy=0 done=0 cnt=%0d", bus.busy_o, bus.done_o, bus.wb_count_o, exp_cnt);
        end
        checks++;
        if (exp_wr.size() != 0 || exp_wb.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got wr_left=%0d wb_left=%0d required 0 0", exp_wr.size(), exp_wb.size());
        end
        exp_wr.delete();
        exp_wb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.mode_i  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.done_o, bus.rd_en_o, bus.rd_set_o, bus.rd_way_o, bus.wr_en_o, bus.wr_set_o, bus.wr_way_o,
             bus.wr_state_o, bus.wb_valid_o, bus.wb_addr_o, bus.wb_count_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%0b rd=%0b wr=%0b wb=%0b cnt=%0d required all 0", bus.busy_o, bus.rd_en_o, bus.wr_en_o, bus.wb_valid_o, bus.wb_count_o);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.done_o, bus.rd_en_o, bus.wr_en_o, bus.wb_valid_o, bus.wb_count_o} !== '0) begin
            errors++;
            $display("FAIL idle_outputs got busy=%0b done=%0b rd=%0b wr=%0b wb=%0b required all 0", bus.busy_o, bus.done_o, bus.rd_en_o, bus.wr_en_o, bus.wb_valid_o);
        end
    endtask

    task automatic test_invalidate_only();
        load_mem(2'b11);
        ready_tie = 1'b1;
        exp_wb_run = 1;
        push_expected(1'b0);
        do_walk(1'b0, 25, 0, 1'b0);
    endtask

    task automatic test_wb_stall();
        for (int i = 0; i < SETS*WAYS; i++) begin
            mem_st[i]  = 2'(i % 3);
            mem_tag[i] = TAG_W'(8'h30 + i);
        end
        mem_st[5]  = 2'b11;
        mem_tag[5] = 8'h5A;
        ready_tie  = 1'b0;
        stall_left = 5;
        exp_wb_run = 6;
        push_expected(1'b1);
        checks++;
        if (exp_wb.size() != 1 || exp_wb[0] !== 10'h16A) begin
            errors++;
            $display("FAIL wb_model got entries=%0d required one entry 16a", exp_wb.size());
        end
        do_walk(1'b1, 31, 1, 1'b0);
    endtask

    task automatic test_start_ignored();
        load_mem(2'b10);
        mem_st[0]  = 2'b11;
        ready_tie  = 1'b1;
        exp_wb_run = 1;
        push_expected(1'b1);
        do_walk(1'b1, 26, 1, 1'b1);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({bus.busy_o, bus.rd_en_o, bus.wb_count_o} !== {2'b00, CNT_W'(1)}) begin
                errors++;
                $display("FAIL second_walk got busy=%0b rd=%0b cnt=%0d required busy=0 rd=0 cnt=1", bus.busy_o, bus.rd_en_o, bus.wb_count_o);
            end
        end
    endtask

    task automatic test_reset_mid_walk();
        int n;
        int k;
        load_mem(2'b01);
        exp_wr.push_back(3'd0);
        exp_wr.push_back(3'd1);
        @(negedge clk);
        bus.mode_i  = 1'b0;
        bus.start_i = 1'b1;
        n = cyc;
        @(negedge clk);
        bus.start_i = 1'b0;
        k = 0;
        while (cyc < n + 8 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ({bus.busy_o, bus.rd_en_o, bus.wr_en_o, bus.rd_set_o, bus.rd_way_o} !== {3'b100, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL check_line10 got busy=%0b rd=%0b wr=%0b set=%0d way=%0d required busy=1 rd=0 wr=0 set=1 way=0", bus.busy_o, bus.rd_en_o, bus.wr_en_o, bus.rd_set_o, bus.rd_way_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.rd_en_o, bus.wr_en_o, bus.wb_valid_o} !== 4'b0000 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL reset_abort got busy=%0b rd=%0b wr=%0b wb=%0b wr_left=%0d required all 0", bus.busy_o, bus.rd_en_o, bus.wr_en_o, bus.wb_valid_o, exp_wr.size());
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.rd_en_o, bus.wr_en_o} !== 3'b000) begin
            errors++;
            $display("FAIL after_reset got busy=%0b rd=%0b wr=%0b required 0 0 0", bus.busy_o, bus.rd_en_o, bus.wr_en_o);
        end
        load_mem(2'b01);
        push_expected(1'b0);
        do_walk(1'b0, 25, 0, 1'b0);
    endtask

    task automatic test_back_to_back_wb();
        load_mem(2'b11);
        ready_tie  = 1'b1;
        exp_wb_run = 1;
        push_expected(1'b1);
        do_walk(1'b1, 33, 8, 1'b0);
    endtask

    initial begin
        test_reset();
        test_invalidate_only();
        test_wb_stall();
        test_start_ignored();
        test_reset_mid_walk();
        test_back_to_back_wb();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
